// File: rtl/feature_transfer_controller_if.sv
// feature_transfer_controller_if: custom-instruction, feature-stream and write-master signals
// master is the controller's view, slave is the CPU/stream/bus side.
interface feature_transfer_controller_if;
    logic        ciStart;
    logic        ciCke;
    logic [7:0]  ciN;
    logic [31:0] ciValueA;
    logic [31:0] ciValueB;
    logic        ciDone;
    logic [31:0] ciResult;
    logic        frameStart;
    logic        frameEnd;
    logic        featureValid;
    logic [31:0] featureData;
    logic        featureReady;
    logic        wrRequest;
    logic [31:0] wrAddress;
    logic [31:0] wrData;
    logic        wrGrant;
    logic        dataReady;
    logic [31:0] numberOfFeatures;

    modport master (
        input  ciStart, ciCke, ciN, ciValueA, ciValueB, frameStart, frameEnd,
               featureValid, featureData, wrGrant,
        output ciDone, ciResult, featureReady, wrRequest, wrAddress, wrData,
               dataReady, numberOfFeatures
    );

    modport slave (
        output ciStart, ciCke, ciN, ciValueA, ciValueB, frameStart, frameEnd,
               featureValid, featureData, wrGrant,
        input  ciDone, ciResult, featureReady, wrRequest, wrAddress, wrData,
               dataReady, numberOfFeatures
    );
endinterface

// File: rtl/feature_transfer_controller.sv
// feature_transfer_controller: arms via custom instruction, writes one frame of features to memory
// through a single-beat write master and reports the feature count at frame end.
module feature_transfer_controller #(
    parameter logic [7:0]  CUSTOM_INSTRUCTION_ID = 8'd0,
    parameter logic [31:0] MAX_FEATURES_RESET    = 32'd256
) (
    input logic clock,
    input logic reset,
    feature_transfer_controller_if.master bus
);
    typedef enum logic [2:0] {IDLE, ARMED, CAPTURE, WRITE, DONE} state_t;

    state_t      state, state_next;
    logic [31:0] base_address, max_features, count, last_count, wr_address, wr_data, ci_result;
    logic        overflow, frame_end_seen, ci_done;
    logic        is_my_ci, busy, arm, ready, handshake, fits;
    logic [1:0]  opcode;
    logic        unused_bits;

    assign unused_bits = ^bus.ciValueA[31:2];
    assign is_my_ci    = bus.ciStart & bus.ciCke & (bus.ciN == CUSTOM_INSTRUCTION_ID);
    assign opcode      = bus.ciValueA[1:0];
    assign busy        = state != IDLE;
    assign arm         = is_my_ci & (opcode == 2'd2) & ~busy;
    assign ready       = reset & (state == IDLE || state == ARMED || state == CAPTURE);
    assign handshake   = bus.featureValid & ready;
    assign fits        = count < max_features;

    assign bus.featureReady     = ready;
    assign bus.wrRequest        = state == WRITE;
    assign bus.wrAddress        = wr_address;
    assign bus.wrData           = wr_data;
    assign bus.dataReady        = state == DONE;
    assign bus.numberOfFeatures = (state == DONE) ? count : last_count;
    assign bus.ciDone           = ci_done;
    assign bus.ciResult         = ci_result;

    always_ff @(posedge clock)
        state <= !reset ? IDLE : state_next;

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    state_next = arm ? ARMED : IDLE;
            ARMED:   state_next = bus.frameStart ? CAPTURE : ARMED;
            CAPTURE: state_next = (handshake & fits) ? WRITE : bus.frameEnd ? DONE : CAPTURE;
            WRITE:   state_next = !bus.wrGrant ? WRITE : (frame_end_seen | bus.frameEnd) ? DONE : CAPTURE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            base_address   <= '0;
            max_features   <= MAX_FEATURES_RESET;
            count          <= '0;
            last_count     <= '0;
            wr_address     <= '0;
            wr_data        <= '0;
            ci_result      <= '0;
            overflow       <= 1'b0;
            frame_end_seen <= 1'b0;
            ci_done        <= 1'b0;
        end else begin
            ci_done   <= is_my_ci;
            ci_result <= '0;
            if (is_my_ci)
                case (opcode)
                    2'd0: begin
                        if (!busy) base_address <= {bus.ciValueB[31:2], 2'b00};
                        ci_result <= {31'd0, ~busy};
                    end
                    2'd1: begin
                        if (!busy) max_features <= bus.ciValueB;
                        ci_result <= {31'd0, ~busy};
                    end
                    2'd2: ci_result <= {31'd0, ~busy};
                    default: ci_result <= {overflow, busy, 14'd0, count[15:0]};
                endcase
            if (arm) begin
                count          <= '0;
                overflow       <= 1'b0;
                frame_end_seen <= 1'b0;
            end
            if (state == CAPTURE && handshake) begin
                if (fits) begin
                    wr_data        <= bus.featureData;
                    wr_address     <= base_address + (count << 2);
                    frame_end_seen <= bus.frameEnd;
                end else begin
                    overflow <= 1'b1;
                end
            end
            if (state == WRITE) begin
                if (bus.frameEnd) frame_end_seen <= 1'b1;
                if (bus.wrGrant) count <= count + 32'd1;
            end
            if (state == DONE) last_count <= count;
        end
    end
endmodule

// File: tb/tb_feature_transfer_controller.sv
// tb_feature_transfer_controller: directed scenarios plus randomized traffic, every cycle
// checked against a frame-level behavioural model of the controller.
module tb_feature_transfer_controller;
    logic clock = 1'b0;
    logic reset = 1'b0;
    always #5 clock = ~clock;

    feature_transfer_controller_if bus();
    feature_transfer_controller dut (.clock(clock), .reset(reset), .bus(bus));

    int compared = 0;
    int mismatched = 0;

    // model: phase 0 idle, 1 waiting for frame, 2 collecting, 3 writing, 4 reporting
    int          p = 0;
    logic [31:0] m_base, m_max, m_cnt, m_last, m_addr, m_data, e_res;
    bit          m_ovf, m_fes, e_done;

    int          wait_cnt = 0, gdly = 2, dr_seen = 0;
    bit          rnd_grant = 0;
    logic [31:0] wq_a[$], wq_d[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_step();
        bit my, busy, hs;
        logic [1:0] op;
        if (!reset) begin
            p = 0; m_base = 0; m_max = 32'd256; m_cnt = 0; m_last = 0;
            m_addr = 0; m_data = 0; m_ovf = 0; m_fes = 0; e_done = 0; e_res = 0;
        end else begin
            hs   = bus.featureValid && p <= 2;
            my   = bus.ciStart && bus.ciCke && bus.ciN == 8'd0;
            busy = p != 0;
            op   = bus.ciValueA[1:0];
            e_done = my;
            e_res  = 0;
            if (my) begin
                if (op == 2'd3) e_res = {m_ovf, busy, 14'd0, m_cnt[15:0]};
                else e_res = busy ? 32'd0 : 32'd1;
                if (!busy && op == 2'd0) m_base = {bus.ciValueB[31:2], 2'b00};
                if (!busy && op == 2'd1) m_max = bus.ciValueB;
            end
            if (p == 4) begin
                m_last = m_cnt;
                p = 0;
            end else if (p == 0) begin
                if (my && op == 2'd2) begin
                    p = 1; m_cnt = 0; m_ovf = 0; m_fes = 0;
                end
            end else if (p == 1) begin
                if (bus.frameStart) p = 2;
            end else if (p == 2) begin
                if (hs && m_cnt < m_max) begin
                    m_addr = m_base + 4 * m_cnt;
                    m_data = bus.featureData;
                    m_fes  = bus.frameEnd;
                    p = 3;
                end else begin
                    if (hs) m_ovf = 1;
                    if (bus.frameEnd) p = 4;
                end
            end else begin
                if (bus.frameEnd) m_fes = 1;
                if (bus.wrGrant) begin
                    m_cnt = m_cnt + 1;
                    p = m_fes ? 4 : 2;
                end
            end
        end
    endtask

    task automatic compare();
        chk("ciDone", bus.ciDone, e_done);
        chk("ciResult", bus.ciResult, e_res);
        chk("featureReady", bus.featureReady, reset && p <= 2);
        chk("wrRequest", bus.wrRequest, p == 3);
        if (p == 3) begin
            chk("wrAddress", bus.wrAddress, m_addr);
            chk("wrData", bus.wrData, m_data);
        end
        chk("dataReady", bus.dataReady, p == 4);
        chk("numberOfFeatures", bus.numberOfFeatures, p == 4 ? m_cnt : m_last);
        if (bus.dataReady) dr_seen++;
    endtask

    task automatic tick();
        model_step();
        @(posedge clock);
        @(negedge clock);
        compare();
        if (p == 3) begin
            if (wait_cnt == 0 && rnd_grant) gdly = $urandom_range(0, 4);
            bus.wrGrant = wait_cnt >= gdly;
            if (bus.wrGrant) begin
                wq_a.push_back(bus.wrAddress);
                wq_d.push_back(bus.wrData);
            end
            wait_cnt++;
        end else begin
            bus.wrGrant = 1'b0;
            wait_cnt = 0;
        end
    endtask

    task automatic settle(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic wait_phase(input int ph, input string name);
        for (int i = 0; i < 300 && p != ph; i++) tick();
        if (p != ph) chk({name, " timeout"}, p, ph);
    endtask

    task automatic ci(input logic [1:0] op, input logic [31:0] b, input logic [31:0] exp);
        logic [31:0] a;
        a = $urandom;
        a[1:0] = op;
        bus.ciStart = 1; bus.ciCke = 1; bus.ciN = 8'd0; bus.ciValueA = a; bus.ciValueB = b;
        tick();
        chk("ci done pulse", bus.ciDone, 1);
        chk("ci result", bus.ciResult, exp);
        bus.ciStart = 0; bus.ciCke = 0;
    endtask

    task automatic feat(input logic [31:0] d, input logic fe);
        wait_phase(2, "feature ready");
        bus.featureValid = 1; bus.featureData = d; bus.frameEnd = fe;
        tick();
        bus.featureValid = 0; bus.frameEnd = 0;
    endtask

    task automatic pulse_fs();
        bus.frameStart = 1;
        tick();
        bus.frameStart = 0;
    endtask

    task automatic pulse_fe();
        bus.frameEnd = 1;
        tick();
        bus.frameEnd = 0;
    endtask

    initial begin
        int dr0;
        bus.ciStart = 0; bus.ciCke = 0; bus.ciN = 0; bus.ciValueA = 0; bus.ciValueB = 0;
        bus.frameStart = 0; bus.frameEnd = 0; bus.featureValid = 0; bus.featureData = 0;
        bus.wrGrant = 0;
        settle(3);
        chk("reset featureReady", bus.featureReady, 0);
        chk("reset ciResult", bus.ciResult, 0);
        chk("reset wrAddress", bus.wrAddress, 0);
        chk("reset numberOfFeatures", bus.numberOfFeatures, 0);
        reset = 1;
        tick();

        // basic frame of three features
        ci(2'd0, 32'h1000_0003, 1);
        ci(2'd1, 32'd4, 1);
        ci(2'd2, 32'd0, 1);
        pulse_fs();
        feat(32'hA, 0); feat(32'hB, 0); feat(32'hC, 0);
        wait_phase(2, "frame1 drain");
        pulse_fe();
        settle(4);
        chk("f1 writes", wq_a.size(), 3);
        if (wq_a.size() == 3) begin
            chk("f1 addr0", wq_a[0], 32'h1000_0000); chk("f1 data0", wq_d[0], 32'hA);
            chk("f1 addr1", wq_a[1], 32'h1000_0004); chk("f1 data1", wq_d[1], 32'hB);
            chk("f1 addr2", wq_a[2], 32'h1000_0008); chk("f1 data2", wq_d[2], 32'hC);
        end
        chk("f1 dataReady pulses", dr_seen, 1);
        chk("f1 numberOfFeatures", bus.numberOfFeatures, 3);

        // overflow: limit 2, five features
        wq_a.delete(); wq_d.delete();
        ci(2'd1, 32'd2, 1);
        ci(2'd2, 32'd0, 1);
        pulse_fs();
        for (int i = 0; i < 5; i++) feat(32'h100 + i, 0);
        wait_phase(2, "frame2 drain");
        pulse_fe();
        settle(3);
        ci(2'd3, 32'd0, 32'h8000_0002);
        chk("f2 writes", wq_a.size(), 2);
        chk("f2 numberOfFeatures", bus.numberOfFeatures, 2);

        // traffic before ARM and while armed produces nothing
        wq_a.delete(); wq_d.delete();
        dr0 = dr_seen;
        ci(2'd1, 32'd8, 1);
        bus.featureValid = 1;
        for (int i = 0; i < 8; i++) begin
            bus.featureData = $urandom; bus.frameEnd = (i == 3); tick();
        end
        bus.featureValid = 0; bus.frameEnd = 0;
        ci(2'd2, 32'd0, 1);
        bus.featureValid = 1;
        for (int i = 0; i < 8; i++) begin
            bus.featureData = $urandom; bus.frameEnd = (i == 4); tick();
        end
        bus.featureValid = 0; bus.frameEnd = 0;
        chk("idle writes", wq_a.size(), 0);
        chk("idle dataReady", dr_seen, dr0);

        // frameEnd with the last handshake
        gdly = 1;
        pulse_fs();
        feat(32'h11, 0); feat(32'h22, 1);
        settle(6);
        chk("coincident dataReady", dr_seen, dr0 + 1);
        chk("coincident numberOfFeatures", bus.numberOfFeatures, 2);

        // frameEnd during WRITE, grant delayed five cycles
        wq_a.delete(); wq_d.delete();
        gdly = 5;
        ci(2'd2, 32'd0, 1);
        pulse_fs();
        feat(32'h77, 0);
        tick();
        pulse_fe();
        settle(10);
        chk("late fe numberOfFeatures", bus.numberOfFeatures, 1);
        chk("late fe writes", wq_a.size(), 1);
        if (wq_a.size() == 1) chk("late fe data", wq_d[0], 32'h77);

        // configuration locked while busy
        wq_a.delete(); wq_d.delete();
        gdly = 1;
        ci(2'd2, 32'd0, 1);
        pulse_fs();
        feat(32'h99, 0);
        wait_phase(2, "busy drain");
        ci(2'd2, 32'd0, 0);
        ci(2'd0, 32'h2000_0000, 0);
        ci(2'd1, 32'd1, 0);
        ci(2'd3, 32'd0, 32'h4000_0001);
        pulse_fe();
        settle(3);
        wq_a.delete(); wq_d.delete();
        ci(2'd2, 32'd0, 1);
        pulse_fs();
        feat(32'h1, 0); feat(32'h2, 0);
        wait_phase(2, "locked drain");
        pulse_fe();
        settle(3);
        chk("locked numberOfFeatures", bus.numberOfFeatures, 2);
        chk("locked writes", wq_a.size(), 2);
        if (wq_a.size() == 2) chk("locked addr1", wq_a[1], 32'h1000_0004);

        // reset during WRITE, then default limit of 256
        gdly = 1000;
        ci(2'd2, 32'd0, 1);
        pulse_fs();
        feat(32'h5, 0);
        settle(2);
        chk("pre-reset wrRequest", bus.wrRequest, 1);
        dr0 = dr_seen;
        reset = 0;
        tick();
        chk("reset wrRequest", bus.wrRequest, 0);
        chk("reset nof", bus.numberOfFeatures, 0);
        reset = 1;
        settle(2);
        chk("reset no dataReady", dr_seen, dr0);
        gdly = 0;
        wq_a.delete(); wq_d.delete();
        ci(2'd2, 32'd0, 1);
        pulse_fs();
        for (int i = 0; i < 257; i++) feat(i, 0);
        wait_phase(2, "limit drain");
        pulse_fe();
        settle(3);
        ci(2'd3, 32'd0, 32'h8000_0100);
        chk("limit numberOfFeatures", bus.numberOfFeatures, 256);
        chk("limit writes", wq_a.size(), 256);
        if (wq_a.size() == 256) begin
            chk("limit addr0", wq_a[0], 32'h0);
            chk("limit addr255", wq_a[255], 32'h3FC);
        end

        // randomized traffic
        rnd_grant = 1;
        for (int i = 0; i < 5000; i++) begin
            logic [31:0] a;
            bus.featureValid = $urandom_range(0, 1);
            bus.featureData  = $urandom;
            bus.frameStart   = $urandom_range(0, 15) == 0;
            bus.frameEnd     = $urandom_range(0, 11) == 0;
            bus.ciStart      = $urandom_range(0, 4) == 0;
            bus.ciCke        = $urandom_range(0, 5) != 0;
            bus.ciN          = ($urandom_range(0, 4) == 0) ? 8'($urandom_range(1, 255)) : 8'd0;
            a = $urandom;
            bus.ciValueA     = a;
            bus.ciValueB     = (a[1:0] == 2'd1) ? $urandom_range(0, 6) : $urandom;
            reset            = $urandom_range(0, 499) != 0;
            tick();
        end
        reset = 1;
        bus.ciStart = 0; bus.featureValid = 0; bus.frameStart = 0; bus.frameEnd = 0;
        settle(20);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
